// File: rtl/conv1d_pkg.sv
// Shared definitions for the conv1d engine and its autonomous sequencer:
// engine command codes, sequencer state encoding and ring-position arithmetic.
package conv1d_pkg;

  localparam int CMD_START   = 6;
  localparam int CMD_GET_ACC = 7;
  localparam int CMD_SET_X   = 8;
  localparam int CMD_DONE    = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_X,
    S_START,
    S_POLL,
    S_CHECK,
    S_READ,
    S_CAPTURE,
    S_DONE
  } seq_state_t;

  // Advance a ring position, wrapping to 0 at the ring length.
  function automatic logic [31:0] next_ring_pos(input logic [31:0] x, input logic [31:0] len);
    return (x + 32'd1 == len) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/conv1d_seq_fifo.sv
// Synchronous result FIFO with exact occupancy; head data is visible the cycle after a push.
// A push into a full FIFO is accepted only together with a pop; a pop of an empty FIFO is ignored.
module conv1d_seq_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_dat_o,
  output logic              vld_o,
  output logic              full_o,
  output logic [LW-1:0]     level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              pop_ok;
  logic              push_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign vld_o   = (level_q != '0);
  assign pop_ok  = pop_i && vld_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Storage is not reset, so the head is masked while empty.
  assign head_dat_o = vld_o ? mem_q[rd_ptr_q] : '0;
  assign level_o    = level_q;

endmodule

// File: rtl/conv1d_sequencer.sv
// Autonomous conv1d command sequencer: SET_X/START/POLL/GET_ACC per output, results into a FIFO.
// Min 6 cycles per output plus extra POLL/CHECK pairs; stalls in READ while the result FIFO is full.
// Optional CONV1D_SEQ_PERF_EN adds perf_cycles/perf_stall counters, cleared on each accepted start.
module conv1d_sequencer
  import conv1d_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CMD_W      = 7,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        host_en,
  input  logic [CMD_W-1:0]            host_cmd,
  input  logic [DATA_W-1:0]           host_inp0,
  input  logic [DATA_W-1:0]           host_inp1,
  output logic [DATA_W-1:0]           host_ret,
  output logic                        host_ready,
  input  logic                        seq_start,
  input  logic                        seq_abort,
  input  logic [CNT_W-1:0]            seq_num_pos,
  input  logic [CNT_W-1:0]            seq_start_x,
  input  logic [CNT_W-1:0]            seq_ring_len,
  output logic                        seq_busy,
  output logic                        seq_done,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_W-1:0]           res_data,
  output logic [$clog2(FIFO_DEPTH):0] res_level,
  output logic                        eng_en,
  output logic [CMD_W-1:0]            eng_cmd,
  output logic [DATA_W-1:0]           eng_inp0,
  output logic [DATA_W-1:0]           eng_inp1,
`ifdef CONV1D_SEQ_PERF_EN
  output logic [31:0]                 perf_cycles,
  output logic [31:0]                 perf_stall,
`endif
  input  logic [DATA_W-1:0]           eng_ret
);

  seq_state_t       state_q;
  logic [CNT_W-1:0] num_pos_q;
  logic [CNT_W-1:0] ring_len_q;
  logic [CNT_W-1:0] cur_x_q;
  logic [CNT_W-1:0] cur_x_d;
  logic [CNT_W-1:0] pos_cnt_q;
  logic [CNT_W-1:0] pos_cnt_d;
  logic             fifo_full;
  logic             idle;

  assign idle      = (state_q == S_IDLE);
  assign cur_x_d   = CNT_W'(next_ring_pos(32'(cur_x_q), 32'(ring_len_q)));
  assign pos_cnt_d = pos_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      num_pos_q  <= '0;
      ring_len_q <= '0;
      cur_x_q    <= '0;
      pos_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (seq_start) begin
            num_pos_q  <= seq_num_pos;
            ring_len_q <= seq_ring_len;
            cur_x_q    <= seq_start_x;
            pos_cnt_q  <= '0;
            state_q    <= (seq_num_pos == '0) ? S_DONE : S_SET_X;
          end
        end
        S_SET_X: state_q <= S_START;
        S_START: state_q <= S_POLL;
        S_POLL:  state_q <= S_CHECK;
        S_CHECK: state_q <= eng_ret[0] ? S_READ : S_POLL;
        S_READ: begin
          if (!fifo_full) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          cur_x_q   <= cur_x_d;
          pos_cnt_q <= pos_cnt_d;
          state_q   <= (pos_cnt_d == num_pos_q) ? S_DONE : S_SET_X;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // Abort wins over any transition above; the engine is simply left to finish on its own.
      if (seq_abort && !idle && (state_q != S_DONE)) state_q <= S_DONE;
    end
  end

  always_comb begin
    eng_en   = 1'b0;
    eng_cmd  = '0;
    eng_inp0 = '0;
    eng_inp1 = '0;
    unique case (state_q)
      S_IDLE: begin
        eng_en   = host_en;
        eng_cmd  = host_cmd;
        eng_inp0 = host_inp0;
        eng_inp1 = host_inp1;
      end
      S_SET_X: begin
        eng_en   = 1'b1;
        eng_cmd  = CMD_W'(CMD_SET_X);
        eng_inp1 = DATA_W'(cur_x_q);
      end
      S_START: begin
        eng_en  = 1'b1;
        eng_cmd = CMD_W'(CMD_START);
      end
      S_POLL: begin
        eng_en  = 1'b1;
        eng_cmd = CMD_W'(CMD_DONE);
      end
      S_READ: begin
        eng_en  = !fifo_full;
        eng_cmd = CMD_W'(CMD_GET_ACC);
      end
      default: ;
    endcase
  end

  assign host_ready = idle;
  assign seq_busy   = !idle;
  assign seq_done   = (state_q == S_DONE);
  assign host_ret   = idle ? eng_ret : '0;

  conv1d_seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (state_q == S_CAPTURE),
    .push_dat_i (eng_ret),
    .pop_i      (res_ready),
    .head_dat_o (res_data),
    .vld_o      (res_valid),
    .full_o     (fifo_full),
    .level_o    (res_level)
  );

`ifdef CONV1D_SEQ_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (idle && seq_start) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (!idle) perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == S_READ) && fifo_full) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Randomised bench for conv1d_sequencer with a behavioural conv1d engine and result/position scoreboards.
module tb_conv1d_sequencer;
  localparam int DATA_W     = 32;
  localparam int CMD_W      = 7;
  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              host_en = 1'b0;
  logic [CMD_W-1:0]  host_cmd = '0;
  logic [DATA_W-1:0] host_inp0 = '0;
  logic [DATA_W-1:0] host_inp1 = '0;
  logic [DATA_W-1:0] host_ret;
  logic              host_ready;
  logic              seq_start = 1'b0;
  logic              seq_abort = 1'b0;
  logic [CNT_W-1:0]  seq_num_pos = '0;
  logic [CNT_W-1:0]  seq_start_x = '0;
  logic [CNT_W-1:0]  seq_ring_len = '0;
  logic              seq_busy;
  logic              seq_done;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [LW-1:0]     res_level;
  logic              eng_en;
  logic [CMD_W-1:0]  eng_cmd;
  logic [DATA_W-1:0] eng_inp0;
  logic [DATA_W-1:0] eng_inp1;
  logic [DATA_W-1:0] eng_ret;

  always #5 clk = ~clk;

  conv1d_sequencer #(
    .DATA_W(DATA_W), .CMD_W(CMD_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .host_en(host_en), .host_cmd(host_cmd), .host_inp0(host_inp0), .host_inp1(host_inp1),
    .host_ret(host_ret), .host_ready(host_ready),
    .seq_start(seq_start), .seq_abort(seq_abort), .seq_num_pos(seq_num_pos),
    .seq_start_x(seq_start_x), .seq_ring_len(seq_ring_len),
    .seq_busy(seq_busy), .seq_done(seq_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_level(res_level),
    .eng_en(eng_en), .eng_cmd(eng_cmd), .eng_inp0(eng_inp0), .eng_inp1(eng_inp1), .eng_ret(eng_ret)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_res[$];
  logic [CNT_W-1:0]  exp_x[$];
  logic [31:0]       salt = 32'h1234_5678;
  int                eng_delay = 0;
  int                n_done = 0, n_setx = 0, n_poll = 0, n_acc = 0, n_cmd5 = 0;
  logic [1:0]        rdy_mode = 2'd1;
  logic              rnd_rdy = 1'b0;

  assign res_ready = (rdy_mode == 2'd2) ? rnd_rdy : rdy_mode[0];
  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

  function automatic logic [31:0] model_acc(input logic [CNT_W-1:0] x, input logic [31:0] s);
    return (32'(x) * 32'd2654435761) ^ s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural conv1d engine: result ready eng_delay cycles after start, ret registered.
  logic [CNT_W-1:0] ex_q;
  int               busy_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_ret <= '0;
      ex_q    <= '0;
      busy_q  <= 0;
    end else begin
      if (busy_q > 0) busy_q <= busy_q - 1;
      if (eng_en) begin
        case (eng_cmd)
          7'd8: begin ex_q <= eng_inp1[CNT_W-1:0]; eng_ret <= '0; end
          7'd6: begin busy_q <= eng_delay; eng_ret <= '0; end
          7'd9: eng_ret <= {31'd0, busy_q == 0};
          7'd7: eng_ret <= model_acc(ex_q, salt);
          7'd5: eng_ret <= eng_inp0 + eng_inp1;
          default: eng_ret <= '0;
        endcase
      end
    end
  end

  // Monitor: command stream and result scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (seq_done) n_done++;
      if (eng_en && eng_cmd == 7'd5) n_cmd5++;
      if (eng_en && !host_ready) begin
        case (eng_cmd)
          7'd8: begin
            n_setx++;
            if (exp_x.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL setx_unexpected: got x=%0d expected none", eng_inp1);
            end else check("setx_pos", eng_inp1, 32'(exp_x.pop_front()));
          end
          7'd9: n_poll++;
          7'd7: begin
            n_acc++;
            check("get_acc_after_done", 32'(busy_q == 0), 32'd1);
          end
          default: ;
        endcase
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL result_unexpected: got %0h expected none", res_data);
        end else check("result_data", res_data, exp_res.pop_front());
      end
    end
  end

  task automatic start_run(input int np, input int sx, input int rl, input int dly);
    eng_delay    = dly;
    salt         = $urandom;
    seq_num_pos  = CNT_W'(np);
    seq_start_x  = CNT_W'(sx);
    seq_ring_len = CNT_W'(rl);
    for (int k = 0; k < np; k++) begin
      exp_x.push_back(CNT_W'((sx + k) % rl));
      exp_res.push_back(model_acc(CNT_W'((sx + k) % rl), salt));
    end
    seq_start = 1'b1;
    @(posedge clk); #1;
    seq_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int cyc);
    cyc = 1;
    while (seq_done !== 1'b1 && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (seq_done !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s: seq_done not seen within %0d cycles", name, limit);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name, input int limit);
    int c;
    c = 0;
    if (rdy_mode == 2'd0) rdy_mode = 2'd1;
    while (exp_res.size() != 0 && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    check({name, "_drained"}, 32'(exp_res.size()), 32'd0);
    @(posedge clk); #1;
    check({name, "_level0"}, 32'(res_level), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int cyc, d0, s0, a0, p0, c5, np, sx, rl, dly;
    logic [31:0] a, b;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_busy", 32'(seq_busy), 32'd0);
    check("rst_done", 32'(seq_done), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_level", 32'(res_level), 32'd0);
    check("rst_eng_en", 32'(eng_en), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Host passthrough while idle
    a = $urandom; b = $urandom;
    host_en = 1'b1; host_cmd = 7'd5; host_inp0 = a; host_inp1 = b;
    #1;
    check("host_fwd_en", 32'(eng_en), 32'd1);
    check("host_fwd_cmd", 32'(eng_cmd), 32'd5);
    check("host_fwd_inp0", eng_inp0, a);
    @(posedge clk); #1;
    host_en = 1'b0;
    check("host_ret", host_ret, a + b);

    // Ring wrap: positions 7,8,0
    rdy_mode = 2'd1;
    d0 = n_done;
    start_run(3, 7, 9, 2);
    wait_done("wrap_run", 500, cyc);
    check("wrap_done_once", 32'(n_done - d0), 32'd1);
    check("wrap_idle", 32'(host_ready), 32'd1);
    drain("wrap", 100);

    // Minimum latency with an immediately-done engine
    start_run(4, 0, 5, 0);
    wait_done("latency_run", 500, cyc);
    check("latency_cycles", 32'(cyc), 32'd25);
    drain("latency", 100);

    // Slow engine: repeated polls
    p0 = n_poll;
    rdy_mode = 2'd2;
    start_run(2, 4, 6, 20);
    wait_done("slow_run", 1000, cyc);
    check("slow_repeated_polls", 32'((n_poll - p0) > 4), 32'd1);
    drain("slow", 200);

    // FIFO full stall
    rdy_mode = 2'd0;
    d0 = n_done;
    start_run(12, 3, 16, 0);
    cyc = 0;
    while (res_level != LW'(FIFO_DEPTH) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    a0 = n_acc;
    repeat (20) @(posedge clk);
    #1;
    check("stall_level", 32'(res_level), 32'(FIFO_DEPTH));
    check("stall_busy", 32'(seq_busy), 32'd1);
    check("stall_no_acc", 32'(n_acc - a0), 32'd0);
    check("stall_no_done", 32'(n_done - d0), 32'd0);
    rdy_mode = 2'd1;
    wait_done("stall_run", 500, cyc);
    drain("stall", 100);

    // Abort during POLL of the second output
    rdy_mode = 2'd0;
    s0 = n_setx;
    start_run(3, 2, 5, 10);
    cyc = 0;
    while (!((n_setx - s0) == 2 && eng_en && eng_cmd == 7'd9) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached_poll2", 32'(eng_cmd == 7'd9 && eng_en), 32'd1);
    seq_abort = 1'b1;
    @(posedge clk); #1;
    seq_abort = 1'b0;
    check("abort_done", 32'(seq_done), 32'd1);
    @(posedge clk); #1;
    check("abort_idle", 32'(host_ready), 32'd1);
    check("abort_done_pulse", 32'(seq_done), 32'd0);
    check("abort_level", 32'(res_level), 32'd1);
    while (exp_res.size() > 1) void'(exp_res.pop_back());
    exp_x.delete();
    drain("abort", 50);

    // num_pos = 0, host access during start cycle and while busy
    c5 = n_cmd5;
    a = $urandom; b = $urandom;
    host_en = 1'b1; host_cmd = 7'd5; host_inp0 = a; host_inp1 = b;
    seq_num_pos = '0; seq_start = 1'b1;
    #1;
    check("zero_start_host_fwd", 32'(eng_en), 32'd1);
    @(posedge clk); #1;
    seq_start = 1'b0;
    check("zero_done", 32'(seq_done), 32'd1);
    check("zero_busy_no_fwd", 32'(eng_en), 32'd0);
    check("zero_busy_ret", host_ret, 32'd0);
    @(posedge clk); #1;
    host_en = 1'b0;
    check("zero_idle", 32'(host_ready), 32'd1);
    check("zero_cmd5_count", 32'(n_cmd5 - c5), 32'd1);

    // Randomised runs
    for (int it = 0; it < 6; it++) begin
      rl  = $urandom_range(1, 10);
      sx  = $urandom_range(0, rl - 1);
      np  = $urandom_range(1, 7);
      dly = $urandom_range(0, 6);
      rdy_mode = 2'd2;
      d0 = n_done;
      start_run(np, sx, rl, dly);
      wait_done("rand_run", 2000, cyc);
      check("rand_done_once", 32'(n_done - d0), 32'd1);
      drain("rand", 200);
    end

    // Reset asserted mid-run
    rdy_mode = 2'd1;
    start_run(5, 1, 6, 3);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_host_ready", 32'(host_ready), 32'd1);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_eng_en", 32'(eng_en), 32'd0);
    check("midrst_busy", 32'(seq_busy), 32'd0);
    exp_x.delete();
    exp_res.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("final_exp_x_empty", 32'(exp_x.size()), 32'd0);
    check("final_level", 32'(res_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
